// File: rtl/pipe_ctrl_decode.sv
// MIPS ID-stage control decoder with ID/EX control register,
// hazard stall/flush handling and a SYSCALL drain/halt sequencer.
module pipe_ctrl_decode #(
  parameter bit EN_SUBWORD   = 1'b1,
  parameter bit EN_SHIFTV    = 1'b1,
  parameter int DRAIN_CYCLES = 3,
  parameter int ILL_CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [31:0]          instr,
  input  logic                 stall,
  input  logic                 flush,
  input  logic                 resume,
  output logic                 id_ready,
  output logic                 ex_valid,
  output logic                 ex_beq,
  output logic                 ex_bne,
  output logic                 ex_mem_to_reg,
  output logic                 ex_mem_write,
  output logic                 ex_alu_src_b,
  output logic                 ex_reg_write,
  output logic                 ex_reg_dst,
  output logic                 ex_signed_ext,
  output logic                 ex_jal,
  output logic                 ex_jmp,
  output logic                 ex_jr,
  output logic                 ex_syscall,
  output logic                 ex_illegal,
  output logic                 ex_mem_unsigned,
  output logic [1:0]           ex_mem_size,
  output logic [3:0]           ex_alu_op,
  output logic                 halt,
  output logic [ILL_CNT_W-1:0] ill_count
);

  typedef struct packed {
    logic       valid;
    logic       beq;
    logic       bne;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src_b;
    logic       reg_write;
    logic       reg_dst;
    logic       signed_ext;
    logic       jal;
    logic       jmp;
    logic       jr;
    logic       syscall;
    logic       illegal;
    logic       mem_unsigned;
    logic [1:0] mem_size;
    logic [3:0] alu_op;
  } ctl_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t     state;
  logic [3:0] cnt;
  ctl_t       ex_q;
  ctl_t       dec;

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_bits;

  assign op = instr[31:26];
  assign fn = instr[5:0];
  assign unused_bits = ^instr[25:6];

  logic r;
  logic is_sll, is_srl, is_sra, is_sllv, is_srlv, is_srav;
  logic is_jr, is_sys, is_add, is_addu, is_sub;
  logic is_and, is_or, is_nor, is_slt, is_sltu;
  logic is_j, is_jal, is_beq, is_bne;
  logic is_addi, is_addiu, is_slti, is_andi, is_ori;
  logic is_lw, is_sw, is_lb, is_lh, is_lbu, is_lhu;
  logic is_sb, is_sh;
  logic r_alu, i_alu, ld, st, legal;

  assign r        = (op == 6'd0);
  assign is_sll   = r && fn == 6'd0;
  assign is_srl   = r && fn == 6'd2;
  assign is_sra   = r && fn == 6'd3;
  assign is_sllv  = r && fn == 6'd4 && EN_SHIFTV;
  assign is_srlv  = r && fn == 6'd6 && EN_SHIFTV;
  assign is_srav  = r && fn == 6'd7 && EN_SHIFTV;
  assign is_jr    = r && fn == 6'd8;
  assign is_sys   = r && fn == 6'd12;
  assign is_add   = r && fn == 6'd32;
  assign is_addu  = r && fn == 6'd33;
  assign is_sub   = r && fn == 6'd34;
  assign is_and   = r && fn == 6'd36;
  assign is_or    = r && fn == 6'd37;
  assign is_nor   = r && fn == 6'd39;
  assign is_slt   = r && fn == 6'd42;
  assign is_sltu  = r && fn == 6'd43;
  assign is_j     = op == 6'd2;
  assign is_jal   = op == 6'd3;
  assign is_beq   = op == 6'd4;
  assign is_bne   = op == 6'd5;
  assign is_addi  = op == 6'd8;
  assign is_addiu = op == 6'd9;
  assign is_slti  = op == 6'd10;
  assign is_andi  = op == 6'd12;
  assign is_ori   = op == 6'd13;
  assign is_lw    = op == 6'd35;
  assign is_sw    = op == 6'd43;
  assign is_lb    = op == 6'd32 && EN_SUBWORD;
  assign is_lh    = op == 6'd33 && EN_SUBWORD;
  assign is_lbu   = op == 6'd36 && EN_SUBWORD;
  assign is_lhu   = op == 6'd37 && EN_SUBWORD;
  assign is_sb    = op == 6'd40 && EN_SUBWORD;
  assign is_sh    = op == 6'd41 && EN_SUBWORD;

  assign r_alu = is_sll | is_srl | is_sra | is_sllv | is_srlv
               | is_srav | is_add | is_addu | is_sub | is_and
               | is_or | is_nor | is_slt | is_sltu;
  assign i_alu = is_addi | is_addiu | is_slti | is_andi | is_ori;
  assign ld    = is_lw | is_lb | is_lh | is_lbu | is_lhu;
  assign st    = is_sw | is_sb | is_sh;
  assign legal = r_alu | i_alu | ld | st | is_jr | is_sys
               | is_j | is_jal | is_beq | is_bne;

  always_comb begin
    dec = '0;
    dec.valid = 1'b1;
    if (!legal) begin
      dec.illegal = 1'b1;
    end else begin
      dec.beq          = is_beq;
      dec.bne          = is_bne;
      dec.mem_to_reg   = ld;
      dec.mem_write    = st;
      dec.alu_src_b    = i_alu | ld | st;
      dec.reg_write    = r_alu | is_jal | i_alu | ld;
      dec.reg_dst      = r_alu;
      dec.signed_ext   = is_beq | is_bne | is_addi | is_slti | ld | st;
      dec.jal          = is_jal;
      dec.jmp          = is_j;
      dec.jr           = is_jr;
      dec.syscall      = is_sys;
      dec.mem_unsigned = is_lbu | is_lhu;
      unique case (1'b1)
        is_lb | is_lbu | is_sb: dec.mem_size = 2'b11;
        is_lh | is_lhu | is_sh: dec.mem_size = 2'b01;
        default:                dec.mem_size = 2'b00;
      endcase
      unique case (1'b1)
        is_sll | is_sllv:          dec.alu_op = 4'b0000;
        is_sra | is_srav:          dec.alu_op = 4'b0001;
        is_srl | is_srlv:          dec.alu_op = 4'b0010;
        is_add | is_addu | is_addi
          | is_addiu | ld | st:    dec.alu_op = 4'b0101;
        is_sub:                    dec.alu_op = 4'b0110;
        is_and | is_andi:          dec.alu_op = 4'b0111;
        is_or | is_ori:            dec.alu_op = 4'b1000;
        is_nor:                    dec.alu_op = 4'b1010;
        is_slt | is_slti:          dec.alu_op = 4'b1011;
        is_sltu:                   dec.alu_op = 4'b1100;
        default:                   dec.alu_op = 4'b0000;
      endcase
    end
  end

  assign id_ready = !rst && state == RUN && !flush && !stall && id_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      cnt       <= '0;
      ex_q      <= '0;
      halt      <= 1'b0;
      ill_count <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (flush) begin
            ex_q <= '0;
          end else if (!stall) begin
            if (id_valid) begin
              ex_q <= dec;
              if (dec.illegal && ill_count != '1)
                ill_count <= ill_count + ILL_CNT_W'(1);
              if (dec.syscall) begin
                state <= DRAIN;
                cnt   <= 4'(DRAIN_CYCLES);
              end
            end else begin
              ex_q <= '0;
            end
          end
        end
        // flush cannot cancel a drain; only stall freezes it
        DRAIN: begin
          if (!stall) begin
            ex_q <= '0;
            cnt  <= cnt - 4'd1;
            if (cnt == 4'd1) begin
              state <= HALTED;
              halt  <= 1'b1;
            end
          end
        end
        HALTED: begin
          ex_q <= '0;
          if (resume) begin
            state <= RUN;
            halt  <= 1'b0;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  assign ex_valid        = ex_q.valid;
  assign ex_beq          = ex_q.beq;
  assign ex_bne          = ex_q.bne;
  assign ex_mem_to_reg   = ex_q.mem_to_reg;
  assign ex_mem_write    = ex_q.mem_write;
  assign ex_alu_src_b    = ex_q.alu_src_b;
  assign ex_reg_write    = ex_q.reg_write;
  assign ex_reg_dst      = ex_q.reg_dst;
  assign ex_signed_ext   = ex_q.signed_ext;
  assign ex_jal          = ex_q.jal;
  assign ex_jmp          = ex_q.jmp;
  assign ex_jr           = ex_q.jr;
  assign ex_syscall      = ex_q.syscall;
  assign ex_illegal      = ex_q.illegal;
  assign ex_mem_unsigned = ex_q.mem_unsigned;
  assign ex_mem_size     = ex_q.mem_size;
  assign ex_alu_op       = ex_q.alu_op;

endmodule

// File: tb/tb_pipe_ctrl_decode.sv
// Scoreboard bench: two decoder configs driven in lockstep and
// checked against a table-driven reference model.
module tb_pipe_ctrl_decode;

  localparam int DC = 3;

  typedef struct packed {
    logic v, beq, bne, m2r, mw, src, rw, rd, se;
    logic jal, jmp, jr, sys, ill, uns;
    logic [1:0] sz;
    logic [3:0] alu;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    bit         rtype;
    int         cls;
    ctl_t       c;
  } ent_t;

  typedef struct {
    bit   rdy;
    ctl_t ex0;
    ctl_t ex1;
    int   ill0;
    int   ill1;
    bit   hlt;
  } exp_t;

  localparam logic [14:0] V   = 15'h4000, BEQ = 15'h2000;
  localparam logic [14:0] BNE = 15'h1000, M2R = 15'h0800;
  localparam logic [14:0] MW  = 15'h0400, SRC = 15'h0200;
  localparam logic [14:0] RW  = 15'h0100, RD  = 15'h0080;
  localparam logic [14:0] SE  = 15'h0040, JAL = 15'h0020;
  localparam logic [14:0] JMP = 15'h0010, JR  = 15'h0008;
  localparam logic [14:0] SYS = 15'h0004, ILL = 15'h0002;
  localparam logic [14:0] UNS = 15'h0001;

  logic clk = 1'b0;
  logic rst = 1'b0, id_valid = 1'b0, stall = 1'b0;
  logic flush = 1'b0, resume = 1'b0;
  logic [31:0] instr = '0;

  logic rdy0, rdy1, halt0, halt1;
  logic [7:0] ill0;
  logic [1:0] ill1;
  ctl_t d0, d1;

  always #5 clk = ~clk;

  pipe_ctrl_decode u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .instr(instr),
    .stall(stall), .flush(flush), .resume(resume),
    .id_ready(rdy0),
    .ex_valid(d0.v), .ex_beq(d0.beq), .ex_bne(d0.bne),
    .ex_mem_to_reg(d0.m2r), .ex_mem_write(d0.mw),
    .ex_alu_src_b(d0.src), .ex_reg_write(d0.rw),
    .ex_reg_dst(d0.rd), .ex_signed_ext(d0.se),
    .ex_jal(d0.jal), .ex_jmp(d0.jmp), .ex_jr(d0.jr),
    .ex_syscall(d0.sys), .ex_illegal(d0.ill),
    .ex_mem_unsigned(d0.uns), .ex_mem_size(d0.sz),
    .ex_alu_op(d0.alu), .halt(halt0), .ill_count(ill0)
  );

  pipe_ctrl_decode #(
    .EN_SUBWORD(1'b0), .EN_SHIFTV(1'b0),
    .DRAIN_CYCLES(DC), .ILL_CNT_W(2)
  ) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .instr(instr),
    .stall(stall), .flush(flush), .resume(resume),
    .id_ready(rdy1),
    .ex_valid(d1.v), .ex_beq(d1.beq), .ex_bne(d1.bne),
    .ex_mem_to_reg(d1.m2r), .ex_mem_write(d1.mw),
    .ex_alu_src_b(d1.src), .ex_reg_write(d1.rw),
    .ex_reg_dst(d1.rd), .ex_signed_ext(d1.se),
    .ex_jal(d1.jal), .ex_jmp(d1.jmp), .ex_jr(d1.jr),
    .ex_syscall(d1.sys), .ex_illegal(d1.ill),
    .ex_mem_unsigned(d1.uns), .ex_mem_size(d1.sz),
    .ex_alu_op(d1.alu), .halt(halt1), .ill_count(ill1)
  );

  ent_t tbl[$];
  exp_t q[$];
  int n_chk = 0;
  int n_fail = 0;

  // model state
  int   m_st = 0;
  int   m_cnt = 0;
  bit   m_halt = 0;
  ctl_t m_ex[2];
  int   m_ill[2];

  task automatic put(input logic [5:0] op, input logic [5:0] fn,
                     input bit r, input int cls, input logic [14:0] f,
                     input logic [1:0] sz, input logic [3:0] alu);
    ent_t e;
    e.op = op; e.fn = fn; e.rtype = r; e.cls = cls;
    e.c = ctl_t'({f, sz, alu});
    tbl.push_back(e);
  endtask

  task automatic build_table();
    put(0, 32, 1, 0, V|RW|RD, 0, 5);
    put(0, 33, 1, 0, V|RW|RD, 0, 5);
    put(0, 34, 1, 0, V|RW|RD, 0, 6);
    put(0, 36, 1, 0, V|RW|RD, 0, 7);
    put(0, 37, 1, 0, V|RW|RD, 0, 8);
    put(0, 39, 1, 0, V|RW|RD, 0, 10);
    put(0, 42, 1, 0, V|RW|RD, 0, 11);
    put(0, 43, 1, 0, V|RW|RD, 0, 12);
    put(0, 0, 1, 0, V|RW|RD, 0, 0);
    put(0, 2, 1, 0, V|RW|RD, 0, 2);
    put(0, 3, 1, 0, V|RW|RD, 0, 1);
    put(0, 4, 1, 2, V|RW|RD, 0, 0);
    put(0, 6, 1, 2, V|RW|RD, 0, 2);
    put(0, 7, 1, 2, V|RW|RD, 0, 1);
    put(0, 8, 1, 0, V|JR, 0, 0);
    put(0, 12, 1, 0, V|SYS, 0, 0);
    put(2, 0, 0, 0, V|JMP, 0, 0);
    put(3, 0, 0, 0, V|JAL|RW, 0, 0);
    put(4, 0, 0, 0, V|BEQ|SE, 0, 0);
    put(5, 0, 0, 0, V|BNE|SE, 0, 0);
    put(8, 0, 0, 0, V|SRC|RW|SE, 0, 5);
    put(9, 0, 0, 0, V|SRC|RW, 0, 5);
    put(10, 0, 0, 0, V|SRC|RW|SE, 0, 11);
    put(12, 0, 0, 0, V|SRC|RW, 0, 7);
    put(13, 0, 0, 0, V|SRC|RW, 0, 8);
    put(35, 0, 0, 0, V|SRC|SE|RW|M2R, 0, 5);
    put(32, 0, 0, 1, V|SRC|SE|RW|M2R, 3, 5);
    put(33, 0, 0, 1, V|SRC|SE|RW|M2R, 1, 5);
    put(36, 0, 0, 1, V|SRC|SE|RW|M2R|UNS, 3, 5);
    put(37, 0, 0, 1, V|SRC|SE|RW|M2R|UNS, 1, 5);
    put(43, 0, 0, 0, V|SRC|SE|MW, 0, 5);
    put(40, 0, 0, 1, V|SRC|SE|MW, 3, 5);
    put(41, 0, 0, 1, V|SRC|SE|MW, 1, 5);
  endtask

  // cfg 0: all options on; cfg 1: subword and variable shifts off
  function automatic ctl_t decode(input logic [31:0] ins, input int cfg);
    ctl_t c;
    c = ctl_t'({V|ILL, 2'b00, 4'b0000});
    foreach (tbl[i]) begin
      if (tbl[i].op == ins[31:26] &&
          (!tbl[i].rtype || tbl[i].fn == ins[5:0])) begin
        if (tbl[i].cls == 0 || cfg == 0) c = tbl[i].c;
      end
    end
    return c;
  endfunction

  task automatic step(input bit r, input bit v, input logic [31:0] ins,
                      input bit s, input bit f, input bit res);
    exp_t e;
    ctl_t d;
    int mx;
    @(negedge clk);
    rst = r; id_valid = v; instr = ins;
    stall = s; flush = f; resume = res;
    e.rdy = !r && m_st == 0 && !f && !s && v;
    if (r) begin
      m_st = 0; m_cnt = 0; m_halt = 0;
      for (int c = 0; c < 2; c++) begin
        m_ex[c] = '0; m_ill[c] = 0;
      end
    end else if (m_st == 0) begin
      if (f) begin
        m_ex[0] = '0; m_ex[1] = '0;
      end else if (!s) begin
        for (int c = 0; c < 2; c++) begin
          mx = (c == 0) ? 255 : 3;
          d = v ? decode(ins, c) : ctl_t'(0);
          m_ex[c] = d;
          if (d.ill && m_ill[c] < mx) m_ill[c]++;
        end
        if (v && decode(ins, 0).sys) begin
          m_st = 1; m_cnt = DC;
        end
      end
    end else if (m_st == 1) begin
      if (!s) begin
        m_ex[0] = '0; m_ex[1] = '0;
        m_cnt--;
        if (m_cnt == 0) begin
          m_st = 2; m_halt = 1;
        end
      end
    end else begin
      m_ex[0] = '0; m_ex[1] = '0;
      if (res) begin
        m_st = 0; m_halt = 0;
      end
    end
    e.ex0 = m_ex[0]; e.ex1 = m_ex[1];
    e.ill0 = m_ill[0]; e.ill1 = m_ill[1];
    e.hlt = m_halt;
    q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp,
               $time);
    end
  endtask

  // monitor: id_ready mid-cycle, registered outputs after the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("id_ready0", 32'(rdy0), 32'(e.rdy));
        chk("id_ready1", 32'(rdy1), 32'(e.rdy));
        @(posedge clk);
        #1;
        chk("ex_word0", 32'(d0), 32'(e.ex0));
        chk("ex_word1", 32'(d1), 32'(e.ex1));
        chk("ill_count0", 32'(ill0), 32'(e.ill0));
        chk("ill_count1", 32'(ill1), 32'(e.ill1));
        chk("halt0", 32'(halt0), 32'(e.hlt));
        chk("halt1", 32'(halt1), 32'(e.hlt));
      end
    end
  end

  function automatic logic [31:0] rnd_instr();
    logic [31:0] ins;
    int k;
    ins = $urandom;
    k = $urandom_range(0, tbl.size() + 2);
    if (k < tbl.size()) begin
      ins[31:26] = tbl[k].op;
      if (tbl[k].rtype) ins[5:0] = tbl[k].fn;
    end else if (k == tbl.size()) begin
      ins[31:26] = 6'd63;
    end else begin
      ins[31:26] = 6'd0;
      ins[5:0] = (k == tbl.size() + 1) ? 6'd63 : 6'd1;
    end
    return ins;
  endfunction

  localparam logic [31:0] I_ADD  = 32'h0022_1820;
  localparam logic [31:0] I_LW   = 32'h8C22_0004;
  localparam logic [31:0] I_SW   = 32'hAC22_0008;
  localparam logic [31:0] I_SYS  = 32'h0000_000C;
  localparam logic [31:0] I_LB   = 32'h8022_0000;
  localparam logic [31:0] I_SRAV = 32'h0022_1807;
  localparam logic [31:0] I_BAD  = 32'hFC00_0000;

  initial begin
    build_table();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, I_ADD, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, I_LW, 0, 0, 0);
    step(0, 1, I_SW, 1, 0, 0);
    step(0, 1, I_SW, 1, 0, 0);
    step(0, 1, I_SW, 0, 0, 0);
    step(0, 1, I_ADD, 1, 1, 0);
    step(0, 1, I_SYS, 0, 0, 0);
    repeat (DC + 5) step(0, 1, I_ADD, 0, 0, 0);
    step(0, 1, I_ADD, 0, 0, 1);
    step(0, 1, I_ADD, 0, 0, 0);
    step(0, 1, I_SYS, 0, 1, 0);
    repeat (4) step(0, 1, I_ADD, 0, 0, 0);
    step(0, 1, I_LB, 0, 0, 0);
    step(0, 1, I_SRAV, 0, 0, 0);
    repeat (6) step(0, 1, I_BAD, 0, 0, 0);
    step(0, 1, I_SYS, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, I_ADD, 0, 0, 0);
    repeat (3000) begin
      step($urandom_range(0, 199) == 0, $urandom_range(0, 4) != 0,
           rnd_instr(), $urandom_range(0, 4) == 0,
           $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
    end
    step(0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
